// File: rtl/case_4_mul_pkg.sv
// Shared constants, types and the round-robin search used by the multiplier arbiter.
package case_4_mul_pkg;

  localparam int A_WIDTH  = 7;
  localparam int B_WIDTH  = 2;
  localparam int P_WIDTH  = 9;
  localparam int ID_WIDTH = 2;
  localparam int MAX_REQ  = 8;

  typedef logic [ID_WIDTH-1:0] req_id_t;

  // Returns {found, index}: first set bit of valid searching from ptr+1
  // upward, wrapping modulo n. Index is meaningless when found is 0.
  function automatic logic [3:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [2:0]         ptr,
                                         input int                 n);
    logic       found;
    logic [2:0] idx;
    int         cand;
    found = 1'b0;
    idx   = 3'd0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      if (!found && k <= n) begin
        cand = (int'(ptr) + k) % n;
        if (valid[cand]) begin
          found = 1'b1;
          idx   = 3'(cand);
        end
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/case_4_mul_7ns_2s_9_1_1.sv
// Shared datapath: 7-bit unsigned x 2-bit signed -> 9-bit signed, purely combinational.
module case_4_mul_7ns_2s_9_1_1 #(
  parameter int ID          = 1,
  parameter int NUM_STAGE   = 0,
  parameter int din0_WIDTH  = 7,
  parameter int din1_WIDTH  = 2,
  parameter int dout_WIDTH  = 9
) (
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [dout_WIDTH-1:0] dout
);

  logic signed [dout_WIDTH-1:0] a_ext;
  logic signed [dout_WIDTH-1:0] b_ext;

  // Zero-extend A (unsigned), sign-extend B, multiply modulo 2^dout_WIDTH.
  always_comb begin
    a_ext = dout_WIDTH'($signed({1'b0, din0}));
    b_ext = dout_WIDTH'($signed(din1));
    dout  = a_ext * b_ext;
  end

endmodule

// File: rtl/case_4_mul_share_arb.sv
// Round-robin arbiter sharing one combinational multiplier among NUM_REQ
// requesters; the response register is the only pipeline stage.
module case_4_mul_share_arb
  import case_4_mul_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0] req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_WIDTH-1:0]        rsp_id,
  output logic [P_WIDTH-1:0]         rsp_data
);

  logic [ID_WIDTH-1:0] ptr_q, ptr_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [ID_WIDTH-1:0] rsp_id_q, rsp_id_d;
  logic [P_WIDTH-1:0]  rsp_data_q, rsp_data_d;

  logic [3:0]          pick;
  logic                found;
  logic [ID_WIDTH-1:0] gidx;
  logic                can_accept;
  logic                xfer;
  logic [A_WIDTH-1:0]  a_sel;
  logic [B_WIDTH-1:0]  b_sel;
  logic [P_WIDTH-1:0]  product;

  case_4_mul_7ns_2s_9_1_1 #(
    .ID         (1),
    .NUM_STAGE  (0),
    .din0_WIDTH (A_WIDTH),
    .din1_WIDTH (B_WIDTH),
    .dout_WIDTH (P_WIDTH)
  ) u_mul (
    .din0 (a_sel),
    .din1 (b_sel),
    .dout (product)
  );

  // Arbitration, accept strobes and next-state for the response slot and pointer.
  always_comb begin
    pick       = rr_pick(MAX_REQ'(req_valid), 3'(ptr_q), NUM_REQ);
    found      = pick[3];
    gidx       = ID_WIDTH'(pick[2:0]);
    can_accept = !rsp_valid_q || rsp_ready;
    xfer       = found && can_accept && ap_rst_n;

    req_ready  = '0;
    if (xfer) req_ready[gidx] = 1'b1;

    a_sel = req_a[gidx*A_WIDTH +: A_WIDTH];
    b_sel = req_b[gidx*B_WIDTH +: B_WIDTH];

    ptr_d       = ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    if (xfer) begin
      ptr_d       = gidx;
      rsp_valid_d = 1'b1;
      rsp_id_d    = gidx;
      rsp_data_d  = product;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // Response register and round-robin pointer; pointer resets so requester 0 wins first.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      ptr_q       <= ID_WIDTH'(NUM_REQ - 1);
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_case_4_mul_share_arb.sv
// Directed bench for the shared-multiplier arbiter.
module tb_case_4_mul_share_arb;
  import case_4_mul_pkg::*;

  localparam int N = 4;

  logic                 ap_clk = 1'b0;
  logic                 ap_rst_n;
  logic [N-1:0]         req_valid;
  logic [N-1:0]         req_ready;
  logic [N*A_WIDTH-1:0] req_a;
  logic [N*B_WIDTH-1:0] req_b;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [1:0]           rsp_id;
  logic [P_WIDTH-1:0]   rsp_data;

  int vectors    = 0;
  int miscompares = 0;

  // per-requester expected products for the fixed operand set below
  logic [P_WIDTH-1:0] exp_p [N];

  case_4_mul_share_arb #(.NUM_REQ(N), .ID_WIDTH(2)) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic check_rsp(input string tag, input logic [1:0] id, input logic [P_WIDTH-1:0] data);
    check({tag, "_valid"}, 32'(rsp_valid), 1);
    check({tag, "_id"},    32'(rsp_id),    32'(id));
    check({tag, "_data"},  32'(rsp_data),  32'(data));
  endtask

  initial begin
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    ap_rst_n  = 1'b0;
    #12;
    check("rst_valid", 32'(rsp_valid), 0);
    check("rst_id",    32'(rsp_id),    0);
    check("rst_data",  32'(rsp_data),  0);
    check("rst_ready", 32'(req_ready), 0);
    ap_rst_n = 1'b1;

    // idle after reset release
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_valid", 32'(rsp_valid), 0);
      check("idle_ready", 32'(req_ready), 0);
    end

    // single request from requester 2: 127 * -2 = -254
    req_a[2*A_WIDTH +: A_WIDTH] = 7'd127;
    req_b[2*B_WIDTH +: B_WIDTH] = 2'b10;
    req_valid = 4'b0100;
    #1 check("single_ready", 32'(req_ready), 32'b0100);
    step();
    req_valid = '0;
    check_rsp("single", 2'd2, 9'h102);
    #1 check("single_ready_drop", 32'(req_ready), 0);
    step();
    check("single_consumed", 32'(rsp_valid), 0);

    // operand set: r0 5*1=5, r1 100*-1=-100, r2 0*-1=0, r3 127*1=127
    req_a = {7'd127, 7'd0, 7'd100, 7'd5};
    req_b = {2'b01, 2'b11, 2'b11, 2'b01};
    exp_p[0] = 9'h005;
    exp_p[1] = 9'h19C;
    exp_p[2] = 9'h000;
    exp_p[3] = 9'h07F;

    // all valid; pointer is at 2 after the single request, so grants run 3,0,1,2,3
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      int g;
      g = (3 + k) % 4;
      #1 check("rr_ready", 32'(req_ready), 32'(1 << g));
      step();
      check_rsp("rr", 2'(g), exp_p[g]);
    end

    // backpressure with response from requester 3 pending
    rsp_ready = 1'b0;
    #1 check("bp_ready0", 32'(req_ready), 0);
    for (int k = 0; k < 5; k++) begin
      step();
      check_rsp("bp_hold", 2'd3, exp_p[3]);
      check("bp_ready", 32'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    #1 check("bp_refill_ready", 32'(req_ready), 32'b0001);
    step();
    check_rsp("bp_refill", 2'd0, exp_p[0]);

    // fairness: r0 always valid, r3 asserts once and wins next
    req_valid = 4'b0001;
    #1 check("fair0_ready", 32'(req_ready), 32'b0001);
    step();
    check_rsp("fair0", 2'd0, exp_p[0]);
    req_valid = 4'b1001;
    #1 check("fair3_ready", 32'(req_ready), 32'b1000);
    step();
    check_rsp("fair3", 2'd3, exp_p[3]);
    req_valid = 4'b0001;
    #1 check("fair_back_ready", 32'(req_ready), 32'b0001);
    step();
    check_rsp("fair_back", 2'd0, exp_p[0]);

    // reset mid-stream with a response pending and pointer at 0
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    #3 ap_rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(rsp_valid), 0);
    check("mid_rst_id",    32'(rsp_id),    0);
    check("mid_rst_data",  32'(rsp_data),  0);
    check("mid_rst_ready", 32'(req_ready), 0);
    step();
    #3 ap_rst_n = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    step();
    check("post_rst_no_stale", 32'(rsp_valid), 0);
    req_valid = 4'b1111;
    #1 check("post_rst_ready", 32'(req_ready), 32'b0001);
    step();
    check_rsp("post_rst", 2'd0, exp_p[0]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
